ra_packetizer_mc: RTL and testbench

Multi-channel remote-access packetizer for a core's cache ports. It turns per-channel read/write requests into NoC flits, and arbitrates the channels round-robin, keeping each write packet atomic. It also reassembles response flits back into per-channel address/data/valid strobes. It sits between the core's cache interfaces and the VC-allocating packetizer. It generalises the two-port (instruction/data) remote-access packetizer to CHANNELS ports and allows at most one outstanding transaction per channel.

---
 rtl/ra_packetizer_mc.sv | 212 +++++++++++++++++++++
 tb/tb_ra_packetizer_mc.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ra_packetizer_mc.sv
// ra_packetizer_mc: multi-channel remote-access packetizer.
// Round-robin flit arbitration with atomic write packets and response reassembly.
module ra_packetizer_mc #(
   parameter int CORE           = 0,
   parameter int CHANNELS       = 2,
   parameter int DATA_WIDTH     = 32,
   parameter int ADDRESS_BITS   = 32,
   parameter int REAL_ADDR_BITS = 16,
   parameter int VC_BITS        = 1,
   parameter int ID_BITS        = 4,
   parameter int EXTRA          = 2,
   parameter int TYPE_BITS      = 2,
   localparam int FLIT_WIDTH    =
      2*ID_BITS+EXTRA+TYPE_BITS+VC_BITS+DATA_WIDTH
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [CHANNELS-1:0]            c2n_read,
   input  logic [CHANNELS-1:0]            c2n_write,
   input  logic [CHANNELS*ADDRESS_BITS-1:0] c2n_addr,
   input  logic [CHANNELS*DATA_WIDTH-1:0] c2n_data,
   output logic [CHANNELS*ADDRESS_BITS-1:0] n2c_addr,
   output logic [CHANNELS*DATA_WIDTH-1:0] n2c_data,
   output logic [CHANNELS-1:0]            n2c_valid,
   output logic [CHANNELS-1:0]            n2c_ready,
   output logic [FLIT_WIDTH-1:0]          flit_to_send,
   output logic                           v_send_flit,
   input  logic [FLIT_WIDTH-1:0]          flit_received,
   input  logic                           v_rec_flit,
   input  logic                           ready
);

   localparam int DW     = DATA_WIDTH;
   localparam int AB     = ADDRESS_BITS;
   localparam int VC_LSB = DW;
   localparam int TY_LSB = DW + VC_BITS;
   localparam int SF_LSB = TY_LSB + TYPE_BITS;
   localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   localparam logic [TYPE_BITS-1:0] T_HEAD = TYPE_BITS'(2'b10);
   localparam logic [TYPE_BITS-1:0] T_BODY = TYPE_BITS'(2'b00);
   localparam logic [TYPE_BITS-1:0] T_TAIL = TYPE_BITS'(2'b01);
   localparam logic [TYPE_BITS-1:0] T_ALL  = TYPE_BITS'(2'b11);

   typedef enum logic [1:0] {
      IDLE,
      SEND0,
      SEND1,
      WAIT
   } state_t;

   state_t                state    [CHANNELS];
   state_t                state_nx [CHANNELS];
   logic [FLIT_WIDTH-1:0] head_q   [CHANNELS];
   logic [FLIT_WIDTH-1:0] tail_q   [CHANNELS];
   logic [FLIT_WIDTH-1:0] head_nx  [CHANNELS];
   logic [FLIT_WIDTH-1:0] tail_nx  [CHANNELS];
   logic [CHANNELS-1:0]   is_wr_q;
   logic [CHANNELS-1:0]   accept;
   logic [CHANNELS-1:0]   gnt;
   logic [CHANNELS-1:0]   rx_hit;
   logic [CHANNELS-1:0]   cpl;

   logic [IDX_W-1:0]      last_grant;
   logic [IDX_W-1:0]      grant_idx;
   logic [IDX_W-1:0]      lock_idx;
   logic [IDX_W-1:0]      cand;
   logic                  grant_vld;
   logic                  lock_vld;
   logic [FLIT_WIDTH-1:0] grant_flit;
   logic [AB-1:0]         addr_c;
   logic [ID_BITS-1:0]    dst_c;

   logic [TYPE_BITS-1:0]  rx_type;
   logic [EXTRA-1:0]      rx_sub;
   logic [DW-1:0]         rx_pay;
   logic                  unused_rx;

   assign rx_type = flit_received[TY_LSB +: TYPE_BITS];
   assign rx_sub  = flit_received[SF_LSB +: EXTRA];
   assign rx_pay  = flit_received[DW-1:0];
   assign unused_rx = ^{flit_received[FLIT_WIDTH-1:SF_LSB+EXTRA],
                        flit_received[VC_LSB +: VC_BITS]};

   always_comb begin
      addr_c  = '0;
      dst_c   = '0;
      accept  = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         addr_c = c2n_addr[c*AB +: AB];
         dst_c  = ID_BITS'(addr_c >> REAL_ADDR_BITS);
         accept[c] = (state[c] == IDLE) && (c2n_read[c] || c2n_write[c]);
         head_nx[c] = {ID_BITS'(CORE), dst_c, EXTRA'(c),
                       c2n_write[c] ? T_HEAD : T_ALL,
                       VC_BITS'(0), DW'(addr_c)};
         tail_nx[c] = {ID_BITS'(CORE), dst_c, EXTRA'(c), T_TAIL,
                       VC_BITS'(0), c2n_data[c*DW +: DW]};
      end
   end

   // A channel in SEND1 owns the link until its tail leaves.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      lock_vld  = 1'b0;
      lock_idx  = '0;
      cand      = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (state[c] == SEND1) begin
            lock_vld = 1'b1;
            lock_idx = IDX_W'(c);
         end
      end
      if (ready) begin
         if (lock_vld) begin
            grant_vld = 1'b1;
            grant_idx = lock_idx;
         end else begin
            for (int i = 1; i <= CHANNELS; i++) begin
               cand = IDX_W'((int'(last_grant) + i) % CHANNELS);
               if (!grant_vld && state[cand] == SEND0) begin
                  grant_vld = 1'b1;
                  grant_idx = cand;
               end
            end
         end
      end
   end

   assign grant_flit = (state[grant_idx] == SEND1) ?
                       tail_q[grant_idx] : head_q[grant_idx];

   always_comb begin
      gnt       = '0;
      rx_hit    = '0;
      cpl       = '0;
      n2c_ready = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         gnt[c]       = grant_vld && (grant_idx == IDX_W'(c));
         rx_hit[c]    = v_rec_flit && (32'(rx_sub) == CHANNELS + c);
         cpl[c]       = rx_hit[c] &&
                        (rx_type == T_ALL || rx_type == T_TAIL);
         n2c_ready[c] = (state[c] == IDLE);
      end
   end

   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         state_nx[c] = state[c];
         unique case (state[c])
            IDLE:  if (accept[c]) state_nx[c] = SEND0;
            SEND0: if (gnt[c]) state_nx[c] = is_wr_q[c] ? SEND1 : WAIT;
            SEND1: if (gnt[c]) state_nx[c] = WAIT;
            WAIT:  if (cpl[c]) state_nx[c] = IDLE;
            default: state_nx[c] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int c = 0; c < CHANNELS; c++) state[c] <= IDLE;
         last_grant   <= IDX_W'(CHANNELS - 1);
         flit_to_send <= '0;
         v_send_flit  <= 1'b0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) state[c] <= state_nx[c];
         if (grant_vld) last_grant <= grant_idx;
         flit_to_send <= grant_vld ? grant_flit : '0;
         v_send_flit  <= grant_vld;
      end
   end

   always_ff @(posedge clock) begin
      for (int c = 0; c < CHANNELS; c++) begin
         if (accept[c]) begin
            head_q[c]  <= head_nx[c];
            tail_q[c]  <= tail_nx[c];
            is_wr_q[c] <= c2n_write[c];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         n2c_addr  <= '0;
         n2c_data  <= '0;
         n2c_valid <= '0;
      end else begin
         n2c_valid <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            if (rx_hit[c]) begin
               case (rx_type)
                  T_ALL: begin
                     n2c_addr[c*AB +: AB] <= AB'(rx_pay);
                     n2c_data[c*DW +: DW] <= '0;
                     n2c_valid[c]         <= 1'b1;
                  end
                  T_HEAD: n2c_addr[c*AB +: AB] <= AB'(rx_pay);
                  T_TAIL: begin
                     n2c_data[c*DW +: DW] <= rx_pay;
                     n2c_valid[c]         <= 1'b1;
                  end
                  T_BODY: ;
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_ra_packetizer_mc.sv
// tb_ra_packetizer_mc: directed tables, corner sequences and a
// randomized run against a flit-queue reference model.
module tb_ra_packetizer_mc;

   localparam int CH  = 2;
   localparam int DW  = 32;
   localparam int AB  = 32;
   localparam int VB  = 1;
   localparam int IB  = 4;
   localparam int EX  = 2;
   localparam int TB  = 2;
   localparam int FW  = 2*IB+EX+TB+VB+DW;
   localparam logic [1:0] HEAD = 2'b10;
   localparam logic [1:0] BODY = 2'b00;
   localparam logic [1:0] TAIL = 2'b01;
   localparam logic [1:0] ALL  = 2'b11;

   logic clock = 1'b0;
   logic reset;
   logic [CH-1:0]    c2n_read, c2n_write, n2c_valid, n2c_ready;
   logic [CH*AB-1:0] c2n_addr, n2c_addr;
   logic [CH*DW-1:0] c2n_data, n2c_data;
   logic [FW-1:0]    flit_to_send, flit_received;
   logic             v_send_flit, v_rec_flit, ready;

   int checks = 0;
   int fails  = 0;

   always #5 clock = ~clock;

   ra_packetizer_mc dut (
      .clock(clock), .reset(reset),
      .c2n_read(c2n_read), .c2n_write(c2n_write),
      .c2n_addr(c2n_addr), .c2n_data(c2n_data),
      .n2c_addr(n2c_addr), .n2c_data(n2c_data),
      .n2c_valid(n2c_valid), .n2c_ready(n2c_ready),
      .flit_to_send(flit_to_send), .v_send_flit(v_send_flit),
      .flit_received(flit_received), .v_rec_flit(v_rec_flit),
      .ready(ready)
   );

   function automatic logic [FW-1:0] mk(input int dst, input int sub,
                                        input logic [1:0] ty,
                                        input logic [31:0] pay);
      return {4'(0), 4'(dst), 2'(sub), ty, 1'b0, pay};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_in();
      c2n_read = '0; c2n_write = '0;
      c2n_addr = '0; c2n_data = '0;
      flit_received = '0; v_rec_flit = 1'b0;
      ready = 1'b1;
   endtask

   task automatic do_reset();
      idle_in();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic chk_flit(input string nm, input logic [FW-1:0] f);
      chk({nm, "_v"}, v_send_flit, 1'b1);
      chk({nm, "_flit"}, flit_to_send, f);
   endtask

   task automatic chk_quiet(input string nm);
      chk({nm, "_v"}, v_send_flit, 1'b0);
      chk({nm, "_flit"}, flit_to_send, '0);
   endtask

   typedef struct {
      logic [1:0]    rd;
      logic [31:0]   addr0;
      logic          vrec;
      logic [FW-1:0] rflit;
      logic          v;
      logic [FW-1:0] flit;
      logic [1:0]    rdy;
      logic [1:0]    val;
      logic [31:0]   d0;
   } vec_t;

   vec_t tbl [6];

   // reference model: per-channel flit queues plus a busy flag
   logic [FW-1:0] pq [CH][2];
   int            pn [CH];
   bit            busy [CH];
   int            lg, lock;
   logic [CH*AB-1:0] m_addr;
   logic [CH*DW-1:0] m_data;
   logic [CH-1:0]    m_valid;
   logic             m_v;
   logic [FW-1:0]    m_flit;

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         pn[c] = 0;
         busy[c] = 1'b0;
      end
      lg = CH - 1; lock = -1;
      m_addr = '0; m_data = '0; m_valid = '0;
      m_v = 1'b0; m_flit = '0;
   endtask

   task automatic model_edge();
      bit bpre [CH];
      int npre [CH];
      int g;
      logic [1:0] ty;
      logic [31:0] pay, a;
      bit done;
      for (int c = 0; c < CH; c++) begin
         bpre[c] = busy[c];
         npre[c] = pn[c];
      end
      g = -1; m_v = 1'b0; m_flit = '0; m_valid = '0;
      if (ready) begin
         if (lock >= 0) g = lock;
         else
            for (int i = 1; i <= CH; i++)
               if (g < 0 && pn[(lg + i) % CH] > 0) g = (lg + i) % CH;
      end
      if (g >= 0) begin
         m_v = 1'b1;
         m_flit = pq[g][0];
         pq[g][0] = pq[g][1];
         pn[g]--;
         lg = g;
         lock = (pn[g] > 0) ? g : -1;
      end
      ty  = flit_received[33 +: 2];
      pay = flit_received[31:0];
      for (int c = 0; c < CH; c++) begin
         done = 1'b0;
         if (v_rec_flit && int'(flit_received[35 +: 2]) == CH + c) begin
            if (ty == ALL) begin
               m_addr[c*AB +: AB] = pay;
               m_data[c*DW +: DW] = '0;
               m_valid[c] = 1'b1; done = 1'b1;
            end else if (ty == HEAD) begin
               m_addr[c*AB +: AB] = pay;
            end else if (ty == TAIL) begin
               m_data[c*DW +: DW] = pay;
               m_valid[c] = 1'b1; done = 1'b1;
            end
         end
         if (done && bpre[c] && npre[c] == 0) busy[c] = 1'b0;
         if (!bpre[c] && (c2n_read[c] || c2n_write[c])) begin
            a = c2n_addr[c*AB +: AB];
            busy[c] = 1'b1;
            pq[c][0] = mk(int'(a[19:16]), c,
                          c2n_write[c] ? HEAD : ALL, a);
            pq[c][1] = mk(int'(a[19:16]), c, TAIL, c2n_data[c*DW +: DW]);
            pn[c] = c2n_write[c] ? 2 : 1;
         end
      end
   endtask

   logic [31:0] A, A0, A1, D0, D1;
   logic [FW-1:0] FR, RT, H0, T0, H1, T1, FR0;
   logic [63:0] rnd;
   logic [CH-1:0] m_rdy;

   initial begin
      A  = 32'h0003_0010;
      FR = mk(3, 0, ALL, A);
      RT = mk(0, 2, TAIL, 32'hDEAD_BEEF);
      tbl[0] = '{2'b01, A, 1'b0, '0, 1'b0, '0, 2'b10, 2'b00, 32'h0};
      tbl[1] = '{2'b01, A, 1'b0, '0, 1'b1, FR, 2'b10, 2'b00, 32'h0};
      tbl[2] = '{2'b01, A, 1'b0, '0, 1'b0, '0, 2'b10, 2'b00, 32'h0};
      tbl[3] = '{2'b01, A, 1'b1, RT, 1'b0, '0, 2'b11, 2'b01,
                 32'hDEAD_BEEF};
      tbl[4] = '{2'b01, A, 1'b0, '0, 1'b0, '0, 2'b10, 2'b00,
                 32'hDEAD_BEEF};
      tbl[5] = '{2'b00, A, 1'b0, '0, 1'b1, FR, 2'b10, 2'b00,
                 32'hDEAD_BEEF};

      do_reset();
      chk("rst_v", v_send_flit, 1'b0);
      chk("rst_flit", flit_to_send, '0);
      chk("rst_ready", n2c_ready, 2'b11);
      chk("rst_valid", n2c_valid, 2'b00);
      chk("rst_addr", n2c_addr, '0);
      chk("rst_data", n2c_data, '0);

      for (int i = 0; i < 6; i++) begin
         c2n_read = tbl[i].rd;
         c2n_addr = {32'h0, tbl[i].addr0};
         v_rec_flit = tbl[i].vrec;
         flit_received = tbl[i].rflit;
         tick();
         chk($sformatf("tbl%0d_v", i), v_send_flit, tbl[i].v);
         chk($sformatf("tbl%0d_flit", i), flit_to_send, tbl[i].flit);
         chk($sformatf("tbl%0d_ready", i), n2c_ready, tbl[i].rdy);
         chk($sformatf("tbl%0d_valid", i), n2c_valid, tbl[i].val);
         chk($sformatf("tbl%0d_d0", i), n2c_data[31:0], tbl[i].d0);
      end

      // simultaneous writes: atomic packets, round-robin order
      A0 = 32'h0005_1000; A1 = 32'h000A_2000;
      D0 = 32'h1111_1111; D1 = 32'h2222_2222;
      H0 = mk(5, 0, HEAD, A0);  T0 = mk(5, 0, TAIL, D0);
      H1 = mk(10, 1, HEAD, A1); T1 = mk(10, 1, TAIL, D1);
      FR0 = mk(5, 0, ALL, A0);
      do_reset();
      c2n_write = 2'b11; c2n_addr = {A1, A0}; c2n_data = {D1, D0};
      tick();
      idle_in();
      chk_quiet("wr_lat");
      chk("wr_busy", n2c_ready, 2'b00);
      tick(); chk_flit("wr_h0", H0);
      tick(); chk_flit("wr_t0", T0);
      tick(); chk_flit("wr_h1", H1);
      tick(); chk_flit("wr_t1", T1);
      tick(); chk_quiet("wr_end");
      v_rec_flit = 1'b1; flit_received = mk(0, 3, ALL, A1);
      tick();
      chk("ack1_valid", n2c_valid, 2'b10);
      chk("ack1_data", n2c_data[63:32], 32'h0);
      chk("ack1_addr", n2c_addr[63:32], A1);
      chk("ack1_ready", n2c_ready, 2'b10);
      flit_received = mk(0, 2, ALL, A0);
      tick();
      chk("ack0_valid", n2c_valid, 2'b01);
      chk("ack0_ready", n2c_ready, 2'b11);
      idle_in();
      c2n_read = 2'b01; c2n_addr = {32'h0, A0};
      tick();
      idle_in();
      tick(); chk_flit("rd0", FR0);
      v_rec_flit = 1'b1; flit_received = mk(0, 2, TAIL, 32'h33);
      tick();
      idle_in();
      chk("rd0_ready", n2c_ready, 2'b11);
      c2n_write = 2'b11; c2n_addr = {A1, A0}; c2n_data = {D1, D0};
      tick();
      idle_in();
      tick(); chk_flit("rr_h1", H1);
      tick(); chk_flit("rr_t1", T1);
      tick(); chk_flit("rr_h0", H0);
      tick(); chk_flit("rr_t0", T0);
      tick(); chk_quiet("rr_end");

      // ready gap inside a write; early completion while in SEND1
      do_reset();
      c2n_write = 2'b10; c2n_addr = {A1, 32'h0}; c2n_data = {D1, 32'h0};
      tick();
      idle_in();
      tick(); chk_flit("gap_h1", H1);
      ready = 1'b0; v_rec_flit = 1'b1;
      flit_received = mk(0, 3, TAIL, 32'h55);
      tick();
      chk_quiet("gap0");
      chk("early_valid", n2c_valid, 2'b10);
      chk("early_data", n2c_data[63:32], 32'h55);
      chk("early_ready", n2c_ready, 2'b01);
      v_rec_flit = 1'b0;
      tick(); chk_quiet("gap1");
      ready = 1'b1;
      tick(); chk_flit("gap_t1", T1);
      tick(); chk_quiet("gap_end");

      // response decode on channel 1
      v_rec_flit = 1'b1; flit_received = mk(0, 3, HEAD, 32'hBEEF);
      tick();
      chk("head_addr", n2c_addr[63:32], 32'hBEEF);
      chk("head_valid", n2c_valid, 2'b00);
      chk("head_ready", n2c_ready, 2'b01);
      flit_received = mk(0, 3, BODY, 32'h1);
      tick();
      chk("body_addr", n2c_addr[63:32], 32'hBEEF);
      chk("body_valid", n2c_valid, 2'b00);
      flit_received = mk(0, 1, ALL, 32'h999);
      tick();
      chk("nomatch_valid", n2c_valid, 2'b00);
      chk("nomatch_addr", n2c_addr, {32'hBEEF, 32'h0});
      flit_received = mk(0, 3, ALL, 32'h777);
      tick();
      chk("wack_valid", n2c_valid, 2'b10);
      chk("wack_data", n2c_data[63:32], 32'h0);
      chk("wack_addr", n2c_addr[63:32], 32'h777);
      chk("wack_ready", n2c_ready, 2'b11);
      v_rec_flit = 1'b0;
      tick();
      chk("hold_valid", n2c_valid, 2'b00);
      chk("hold_addr", n2c_addr[63:32], 32'h777);

      // reset while channel 1 sits in SEND1
      do_reset();
      c2n_write = 2'b10; c2n_addr = {A1, 32'h0}; c2n_data = {D1, 32'h0};
      tick();
      idle_in();
      tick(); chk_flit("mid_h1", H1);
      reset = 1'b1;
      tick();
      chk_quiet("mid_rst");
      chk("mid_ready", n2c_ready, 2'b11);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_quiet($sformatf("mid_post%0d", i));
      end

      // randomized run against the reference model
      do_reset();
      model_reset();
      for (int n = 0; n < 2000; n++) begin
         for (int c = 0; c < CH; c++) begin
            c2n_read[c]  = ($urandom_range(0, 3) == 0);
            c2n_write[c] = ($urandom_range(0, 3) == 0);
         end
         c2n_addr = {$urandom, $urandom};
         c2n_data = {$urandom, $urandom};
         ready = ($urandom_range(0, 3) != 0);
         v_rec_flit = ($urandom_range(0, 2) == 0);
         rnd = {$urandom, $urandom};
         flit_received = rnd[FW-1:0];
         reset = ($urandom_range(0, 199) == 0);
         if (reset) model_reset();
         else model_edge();
         tick();
         for (int c = 0; c < CH; c++) m_rdy[c] = !busy[c];
         chk("rnd_v", v_send_flit, m_v);
         chk("rnd_flit", flit_to_send, m_flit);
         chk("rnd_ready", n2c_ready, m_rdy);
         chk("rnd_valid", n2c_valid, m_valid);
         chk("rnd_addr", n2c_addr, m_addr);
         chk("rnd_data", n2c_data, m_data);
      end
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
